// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Entry widths are fixed here; the arbiter's width parameters must match.
package wb_pkg;
   localparam int WB_A_WIDTH = 5;
   localparam int WB_D_WIDTH = 32;
   localparam int REG_ZERO   = 0;
   localparam int NUM_REGS   = 2**WB_A_WIDTH;

   typedef struct packed {
      logic                  live;
      logic [WB_A_WIDTH-1:0] rd;
      logic [WB_D_WIDTH-1:0] data;
   } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Circular skid buffer of LSU writebacks with kill-by-rd and a live-register mask.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                          clk_in,
   input  logic                          rst_in,
   input  logic                          push,
   input  wb_entry_t                     push_entry,
   input  logic                          pop,
   input  logic                          kill,
   input  logic [WB_A_WIDTH-1:0]         kill_rd,
   output wb_entry_t                     head,
   output logic [$clog2(DEPTH+1)-1:0]    count,
   output logic [NUM_REGS-1:0]           live_mask
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   wb_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;

   // Popped slots drop their live bit, so the mask can OR over every slot.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         mem    <= '{default: '0};
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++)
            if (kill && mem[i].rd == kill_rd) mem[i].live <= 1'b0;
         if (pop) begin
            mem[rd_ptr].live <= 1'b0;
            rd_ptr           <= rd_ptr + PTR_W'(1);
         end
         if (push) begin
            mem[wr_ptr] <= push_entry;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   assign head = mem[rd_ptr];

   always_comb begin
      live_mask = '0;
      for (int i = 0; i < DEPTH; i++)
         if (mem[i].live) live_mask[mem[i].rd] = 1'b1;
   end
endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the register file write port between the ALU (fixed priority)
// and the LSU, buffering colliding loads and exporting a pending-register mask.
module wb_port_arbiter
   import wb_pkg::*;
#(
   parameter int A_WIDTH    = WB_A_WIDTH,
   parameter int D_WIDTH    = WB_D_WIDTH,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  alu_valid_in,
   input  logic [A_WIDTH-1:0]    alu_rd_in,
   input  logic [D_WIDTH-1:0]    alu_data_in,
   input  logic                  lsu_valid_in,
   output logic                  lsu_ready_out,
   input  logic [A_WIDTH-1:0]    lsu_rd_in,
   input  logic [D_WIDTH-1:0]    lsu_data_in,
   output logic                  RegWrite_out,
   output logic [A_WIDTH-1:0]    rd_out,
   output logic [D_WIDTH-1:0]    write_data3_out,
   output logic [2**A_WIDTH-1:0] pending_mask_out
);
   localparam int CNT_W = $clog2(FIFO_DEPTH+1);

   wb_entry_t          head, push_entry;
   logic [CNT_W-1:0]   count;
   logic               alu_wr, lsu_hs, lsu_dead, fifo_empty;
   logic               pop, bypass, push;
   logic               nxt_we;
   logic [A_WIDTH-1:0] nxt_rd;
   logic [D_WIDTH-1:0] nxt_data;

   assign lsu_ready_out = !rst_in && (int'(count) < FIFO_DEPTH);
   assign fifo_empty    = (count == '0);
   assign alu_wr        = alu_valid_in && (alu_rd_in != A_WIDTH'(REG_ZERO));
   assign lsu_hs        = lsu_valid_in && lsu_ready_out;
   // An ALU write to the same rd is younger, so the load result is simply dropped.
   assign lsu_dead      = (lsu_rd_in == A_WIDTH'(REG_ZERO)) || (alu_wr && lsu_rd_in == alu_rd_in);
   assign pop           = !alu_wr && !fifo_empty;
   assign bypass        = !alu_wr && fifo_empty && lsu_hs && !lsu_dead;
   assign push          = lsu_hs && !lsu_dead && !bypass;
   assign push_entry    = '{live: 1'b1, rd: lsu_rd_in, data: lsu_data_in};

   wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .kill       (alu_wr),
      .kill_rd    (alu_rd_in),
      .head       (head),
      .count      (count),
      .live_mask  (pending_mask_out)
   );

   always_comb begin
      nxt_we   = 1'b0;
      nxt_rd   = '0;
      nxt_data = '0;
      if (alu_wr) begin
         nxt_we   = 1'b1;
         nxt_rd   = alu_rd_in;
         nxt_data = alu_data_in;
      end else if (pop) begin
         if (head.live) begin
            nxt_we   = 1'b1;
            nxt_rd   = head.rd;
            nxt_data = head.data;
         end
      end else if (bypass) begin
         nxt_we   = 1'b1;
         nxt_rd   = lsu_rd_in;
         nxt_data = lsu_data_in;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         RegWrite_out    <= 1'b0;
         rd_out          <= '0;
         write_data3_out <= '0;
      end else begin
         RegWrite_out    <= nxt_we;
         rd_out          <= nxt_rd;
         write_data3_out <= nxt_data;
      end
   end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Vector table plus scoreboard bench for wb_port_arbiter, with hand-written reset sequences.
module tb_wb_port_arbiter;
   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        alu_valid_in = 1'b0, lsu_valid_in = 1'b0;
   logic [4:0]  alu_rd_in = '0, lsu_rd_in = '0;
   logic [31:0] alu_data_in = '0, lsu_data_in = '0;
   logic        lsu_ready_out, RegWrite_out;
   logic [4:0]  rd_out;
   logic [31:0] write_data3_out, pending_mask_out;

   int errors = 0;
   int checks = 0;

   wb_port_arbiter dut (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .alu_valid_in     (alu_valid_in),
      .alu_rd_in        (alu_rd_in),
      .alu_data_in      (alu_data_in),
      .lsu_valid_in     (lsu_valid_in),
      .lsu_ready_out    (lsu_ready_out),
      .lsu_rd_in        (lsu_rd_in),
      .lsu_data_in      (lsu_data_in),
      .RegWrite_out     (RegWrite_out),
      .rd_out           (rd_out),
      .write_data3_out  (write_data3_out),
      .pending_mask_out (pending_mask_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic av; logic [4:0] ar; logic [31:0] ad;
      logic lv; logic [4:0] lr; logic [31:0] ld;
      logic we; logic [4:0] rd; logic [31:0] d; logic rdy; logic [31:0] mask;
   } vec_t;

   typedef struct {
      logic we; logic [4:0] rd; logic [31:0] d; logic rdy; logic [31:0] mask; int idx;
   } exp_t;

   vec_t tbl [23];
   exp_t sb_q [$];

   function automatic vec_t mk(logic av, logic [4:0] ar, logic [31:0] ad,
                               logic lv, logic [4:0] lr, logic [31:0] ld,
                               logic we, logic [4:0] rd, logic [31:0] d,
                               logic rdy, logic [31:0] mask);
      vec_t v;
      v.av = av; v.ar = ar; v.ad = ad; v.lv = lv; v.lr = lr; v.ld = ld;
      v.we = we; v.rd = rd; v.d = d; v.rdy = rdy; v.mask = mask;
      return v;
   endfunction

   function automatic logic [31:0] bit_of(int r);
      logic [31:0] m;
      m = '0;
      m[r] = 1'b1;
      return m;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(logic av, logic [4:0] ar, logic [31:0] ad,
                        logic lv, logic [4:0] lr, logic [31:0] ld);
      alu_valid_in = av; alu_rd_in = ar; alu_data_in = ad;
      lsu_valid_in = lv; lsu_rd_in = lr; lsu_data_in = ld;
   endtask

   task automatic check_out(exp_t e);
      string tag;
      tag = $sformatf("v%0d", e.idx);
      chk({tag, ".we"}, 32'(RegWrite_out), 32'(e.we));
      if (e.we) begin
         chk({tag, ".rd"}, 32'(rd_out), 32'(e.rd));
         chk({tag, ".data"}, write_data3_out, e.d);
      end
      chk({tag, ".ready"}, 32'(lsu_ready_out), 32'(e.rdy));
      chk({tag, ".mask"}, pending_mask_out, e.mask);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: timeout reached, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      // Outputs observed one edge after each vector is applied.
      tbl[0]  = mk(0, 0, 0,        0, 0, 0,            0, 0, 0,            1, 0);
      tbl[1]  = mk(0, 0, 0,        1, 5, 32'hDEADBEEF, 1, 5, 32'hDEADBEEF, 1, 0);
      tbl[2]  = mk(1, 3, 32'h11,   1, 7, 32'h22,       1, 3, 32'h11,       1, bit_of(7));
      tbl[3]  = mk(0, 0, 0,        0, 0, 0,            1, 7, 32'h22,       1, 0);
      tbl[4]  = mk(1, 1, 32'h101,  1, 10, 32'hA0,      1, 1, 32'h101,      1, bit_of(10));
      tbl[5]  = mk(1, 2, 32'h102,  1, 11, 32'hA1,      1, 2, 32'h102,      0, bit_of(10) | bit_of(11));
      tbl[6]  = mk(1, 4, 32'h104,  1, 12, 32'hA2,      1, 4, 32'h104,      0, bit_of(10) | bit_of(11));
      tbl[7]  = mk(1, 6, 32'h106,  0, 0, 0,            1, 6, 32'h106,      0, bit_of(10) | bit_of(11));
      tbl[8]  = mk(0, 0, 0,        0, 0, 0,            1, 10, 32'hA0,      1, bit_of(11));
      tbl[9]  = mk(0, 0, 0,        0, 0, 0,            1, 11, 32'hA1,      1, 0);
      tbl[10] = mk(1, 1, 32'h1,    1, 9, 32'hAA,       1, 1, 32'h1,        1, bit_of(9));
      tbl[11] = mk(1, 9, 32'hBB,   0, 0, 0,            1, 9, 32'hBB,       1, 0);
      tbl[12] = mk(0, 0, 0,        0, 0, 0,            0, 0, 0,            1, 0);
      tbl[13] = mk(1, 0, 32'h55,   1, 0, 32'h66,       0, 0, 0,            1, 0);
      tbl[14] = mk(0, 0, 0,        0, 0, 0,            0, 0, 0,            1, 0);
      tbl[15] = mk(1, 8, 32'h80,   1, 8, 32'h88,       1, 8, 32'h80,       1, 0);
      tbl[16] = mk(0, 0, 0,        0, 0, 0,            0, 0, 0,            1, 0);
      tbl[17] = mk(1, 13, 32'hD,   1, 14, 32'hE,       1, 13, 32'hD,       1, bit_of(14));
      tbl[18] = mk(1, 0, 32'h77,   0, 0, 0,            1, 14, 32'hE,       1, 0);
      tbl[19] = mk(1, 0, 32'h9,    1, 15, 32'hF,       1, 15, 32'hF,       1, 0);
      tbl[20] = mk(1, 16, 32'h10,  1, 17, 32'h11,      1, 16, 32'h10,      1, bit_of(17));
      tbl[21] = mk(0, 0, 0,        1, 18, 32'h12,      1, 17, 32'h11,      1, bit_of(18));
      tbl[22] = mk(0, 0, 0,        0, 0, 0,            1, 18, 32'h12,      1, 0);

      // Reset state
      #1;
      chk("reset.we", 32'(RegWrite_out), 0);
      chk("reset.rd", 32'(rd_out), 0);
      chk("reset.data", write_data3_out, 0);
      chk("reset.ready", 32'(lsu_ready_out), 0);
      chk("reset.mask", pending_mask_out, 0);
      @(negedge clk_in);
      rst_in = 1'b0;
      #1;
      chk("post_reset.ready", 32'(lsu_ready_out), 1);

      foreach (tbl[i]) begin
         exp_t e;
         @(negedge clk_in);
         drive(tbl[i].av, tbl[i].ar, tbl[i].ad, tbl[i].lv, tbl[i].lr, tbl[i].ld);
         e.we = tbl[i].we; e.rd = tbl[i].rd; e.d = tbl[i].d;
         e.rdy = tbl[i].rdy; e.mask = tbl[i].mask; e.idx = i;
         sb_q.push_back(e);
         @(posedge clk_in);
         #1;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: queue empty at v%0d", i);
         end else check_out(sb_q.pop_front());
      end

      // Reset mid-operation with two buffered loads
      @(negedge clk_in);
      drive(1, 1, 32'h201, 1, 20, 32'hC0);
      @(negedge clk_in);
      drive(1, 2, 32'h202, 1, 21, 32'hC1);
      @(posedge clk_in);
      #1;
      chk("midrst.pre_we", 32'(RegWrite_out), 1);
      chk("midrst.pre_mask", pending_mask_out, bit_of(20) | bit_of(21));
      chk("midrst.pre_ready", 32'(lsu_ready_out), 0);
      #2;
      rst_in = 1'b1;
      #1;
      chk("midrst.we", 32'(RegWrite_out), 0);
      chk("midrst.rd", 32'(rd_out), 0);
      chk("midrst.data", write_data3_out, 0);
      chk("midrst.ready", 32'(lsu_ready_out), 0);
      chk("midrst.mask", pending_mask_out, 0);
      @(negedge clk_in);
      drive(0, 0, 0, 0, 0, 0);
      rst_in = 1'b0;
      #1;
      chk("midrst.release_ready", 32'(lsu_ready_out), 1);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk_in);
         #1;
         chk($sformatf("midrst.stale_we%0d", k), 32'(RegWrite_out), 0);
         chk($sformatf("midrst.stale_mask%0d", k), pending_mask_out, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Drives the register file's single write port (RegWrite / rd / WD3) from two writeback producers: the in-order ALU pipeline and the variable-latency load/store unit (LSU).
- ALU results have fixed priority and are never stalled.
- LSU results that collide with an ALU write are held in a small FIFO and drained on free cycles.
- A pending-register mask is exported so the hazard unit can stall readers of registers whose load data is still buffered.

Parameters:
A_WIDTH, 5, register address width.
D_WIDTH, 32, register data width.
FIFO_DEPTH, 2, LSU skid-buffer entries; power of two, >= 2.

Ports:
clk_in  input  1  clock; all state on rising edge.
rst_in  input  1  reset; asynchronous, active-high.
alu_valid_in  input  1  ALU result valid this cycle.
alu_rd_in  input  A_WIDTH  ALU destination register.
alu_data_in  input  D_WIDTH  ALU result.
lsu_valid_in  input  1  LSU load result valid.
lsu_ready_out  output  1  arbiter can accept an LSU result this cycle.
lsu_rd_in  input  A_WIDTH  load destination register.
lsu_data_in  input  D_WIDTH  load data.
RegWrite_out  output  1  to register file WE3.
rd_out  output  A_WIDTH  to register file write address.
write_data3_out  output  D_WIDTH  to register file WD3.
pending_mask_out  output  2**A_WIDTH  bit r set when a live FIFO entry targets register r.

Behaviour:
- Reset (asynchronous, active-high):
  - RegWrite_out=0, rd_out=0, write_data3_out=0.
  - FIFO empty; all entry valid bits clear; pending_mask_out=0.
  - lsu_ready_out=0 while rst_in is high.
- Output registers: RegWrite_out / rd_out / write_data3_out are registered. A source selected in cycle N appears at the outputs in cycle N+1, and the register file commits it at the end of N+1.
- An LSU handshake occurs when lsu_valid_in && lsu_ready_out.
- lsu_ready_out = !rst_in && (count < FIFO_DEPTH). It depends on registered count only; there is no combinational path from any *_valid_in.
- Selection each cycle, first match wins:
  1. alu_valid_in && alu_rd_in != 0: output the ALU write.
  2. FIFO non-empty: pop the head. Output the head's write only if its live bit is set; otherwise output RegWrite=0.
  3. LSU handshake and FIFO empty: bypass the LSU result directly to the output if lsu_rd_in != 0.
  4. Otherwise: RegWrite_out=0 next cycle.
- Push rule: an LSU handshake that is not bypassed is pushed to the FIFO tail.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - Pushing while full is impossible because ready is deasserted.
- x0 handling:
  - ALU writes with alu_rd_in=0 are ignored; they do not block the FIFO drain.
  - LSU results with lsu_rd_in=0 complete the handshake but are neither pushed nor output.
  - RegWrite_out is never 1 with rd_out=0.
- Ordering: an LSU result is always older than an ALU result in the same or any later cycle. Therefore:
  - An ALU write to rd R clears the live bit of every FIFO entry with rd R in that cycle. Killed entries still occupy their slot until popped.
  - An LSU handshake in the same cycle as an ALU write to the same nonzero rd is accepted and discarded: no push, no output.
- pending_mask_out is the OR over live FIFO entries of one-hot(rd). It is combinational from registered FIFO state, with no input-to-output path.
- FIFO pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.

Decomposition:
- Shared package wb_pkg holds:
  - typedef wb_entry_t {live, rd[A_WIDTH], data[D_WIDTH]};
  - localparams REG_ZERO=0 and NUM_REGS=2**A_WIDTH.
- One sub-module, wb_fifo: a circular buffer of wb_entry_t with push/pop/count, a per-entry kill-by-rd input, and a live-rd mask output.
- The top level holds the selection logic and the output registers.

Test Plan:
- LSU only: lsu rd=5, data=0xDEADBEEF, alu idle -> next cycle RegWrite=1, rd=5, data=0xDEADBEEF; FIFO stays empty; pending_mask=0.
- Collision: alu rd=3, data=0x11 and lsu rd=7, data=0x22 in cycle N -> N+1 writes x3=0x11; pending_mask bit7=1; N+2 writes x7=0x22; mask returns to 0.
- Backpressure: ALU valid for 4 consecutive cycles with nonzero rd, LSU pushes 2 results -> lsu_ready_out=0 after the second push; both entries drain in order once ALU goes idle; ready returns to 1.
- Kill: FIFO holds load rd=9, data=0xAA; ALU then writes rd=9, data=0xBB -> register file ends with x9=0xBB; the killed pop produces RegWrite=0; mask bit9 clears when the ALU write is accepted.
- x0: alu rd=0 and lsu rd=0 simultaneously, each with nonzero data -> RegWrite_out stays 0 and nothing is pushed.
- Reset mid-operation: rst_in asserted with 2 FIFO entries pending -> outputs go to 0 immediately (asynchronous) and the FIFO is empty; after release, ready=1 and no stale writes appear.
